sdram_port_arbiter: RTL and testbench

Two-requester arbiter in front of port 0 of the `sdram` controller.
- Each requester gets a one-entry pending buffer for its read or write.
- One request at a time is granted and presented to the controller's `p0_*` interface.
- Completion is tracked through `p0_ready`; read data is returned to the owning requester with a one-cycle acknowledge.
- Sits between client logic (e.g. CPU and video fetch) and the controller.

---
 rtl/sdram_port_arbiter.sv | 210 +++++++++++++++++++++
 tb/tb_sdram_port_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: two requesters, one-entry buffers, sdram port 0 master.
// Define SDRAM_ARB_ROUND_ROBIN_EN for round-robin; default is fixed r0 priority.
module sdram_port_arbiter #(
    parameter int ADDR_WIDTH = 21,
    parameter int DATA_WIDTH = 32,
    parameter int BE_WIDTH   = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  init_complete,

    input  logic [ADDR_WIDTH-1:0] r0_addr,
    input  logic [DATA_WIDTH-1:0] r0_data,
    input  logic [BE_WIDTH-1:0]   r0_byte_en,
    input  logic                  r0_wr_req,
    input  logic                  r0_rd_req,
    output logic                  r0_busy,
    output logic                  r0_ack,
    output logic [DATA_WIDTH-1:0] r0_q,

    input  logic [ADDR_WIDTH-1:0] r1_addr,
    input  logic [DATA_WIDTH-1:0] r1_data,
    input  logic [BE_WIDTH-1:0]   r1_byte_en,
    input  logic                  r1_wr_req,
    input  logic                  r1_rd_req,
    output logic                  r1_busy,
    output logic                  r1_ack,
    output logic [DATA_WIDTH-1:0] r1_q,

    output logic [ADDR_WIDTH-1:0] p0_addr,
    output logic [DATA_WIDTH-1:0] p0_data,
    output logic [BE_WIDTH-1:0]   p0_byte_en,
    output logic                  p0_wr_req,
    output logic                  p0_rd_req,
    input  logic [DATA_WIDTH-1:0] p0_q,
    input  logic                  p0_ready
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [1:0] pend_q, pend_d;
    logic [1:0] op_wr_q, op_wr_d;
    logic [1:0] ack_q, ack_d;
    logic       owner_q, owner_d;

    logic [ADDR_WIDTH-1:0] buf_addr_q [2];
    logic [ADDR_WIDTH-1:0] buf_addr_d [2];
    logic [DATA_WIDTH-1:0] buf_data_q [2];
    logic [DATA_WIDTH-1:0] buf_data_d [2];
    logic [BE_WIDTH-1:0]   buf_be_q   [2];
    logic [BE_WIDTH-1:0]   buf_be_d   [2];
    logic [DATA_WIDTH-1:0] rq_q       [2];
    logic [DATA_WIDTH-1:0] rq_d       [2];

    logic [ADDR_WIDTH-1:0] p0_addr_q, p0_addr_d;
    logic [DATA_WIDTH-1:0] p0_data_q, p0_data_d;
    logic [BE_WIDTH-1:0]   p0_be_q, p0_be_d;
    logic                  p0_wr_q, p0_wr_d;
    logic                  p0_rd_q, p0_rd_d;

    logic [1:0]            req_wr;
    logic [1:0]            req_rd;
    logic [ADDR_WIDTH-1:0] req_addr [2];
    logic [DATA_WIDTH-1:0] req_data [2];
    logic [BE_WIDTH-1:0]   req_be   [2];
    logic                  win;

    assign req_wr      = {r1_wr_req, r0_wr_req};
    assign req_rd      = {r1_rd_req, r0_rd_req};
    assign req_addr[0] = r0_addr;
    assign req_addr[1] = r1_addr;
    assign req_data[0] = r0_data;
    assign req_data[1] = r1_data;
    assign req_be[0]   = r0_byte_en;
    assign req_be[1]   = r1_byte_en;

`ifdef SDRAM_ARB_ROUND_ROBIN_EN
    logic rr_ptr_q, rr_ptr_d;

    // r1 wins when alone, or when both wait and the pointer favours it
    assign win = pend_q[1] & (~pend_q[0] | rr_ptr_q);
`else
    assign win = pend_q[1] & ~pend_q[0];
`endif

    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        op_wr_d    = op_wr_q;
        owner_d    = owner_q;
        ack_d      = 2'b00;
        buf_addr_d = buf_addr_q;
        buf_data_d = buf_data_q;
        buf_be_d   = buf_be_q;
        rq_d       = rq_q;
        p0_addr_d  = p0_addr_q;
        p0_data_d  = p0_data_q;
        p0_be_d    = p0_be_q;
        p0_wr_d    = p0_wr_q;
        p0_rd_d    = p0_rd_q;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
        rr_ptr_d   = rr_ptr_q;
`endif

        // a busy requester cannot be captured, so this never races a completion
        for (int n = 0; n < 2; n++) begin
            if ((req_wr[n] || req_rd[n]) && !pend_q[n]) begin
                pend_d[n]     = 1'b1;
                op_wr_d[n]    = req_wr[n];
                buf_addr_d[n] = req_addr[n];
                buf_data_d[n] = req_data[n];
                buf_be_d[n]   = req_be[n];
            end
        end

        unique case (state_q)
            ST_IDLE: begin
                if (init_complete && (pend_q != 2'b00)) begin
                    owner_d   = win;
                    p0_addr_d = buf_addr_q[win];
                    p0_data_d = buf_data_q[win];
                    p0_be_d   = buf_be_q[win];
                    p0_wr_d   = op_wr_q[win];
                    p0_rd_d   = ~op_wr_q[win];
                    state_d   = ST_ISSUE;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
                    rr_ptr_d  = ~win;
`endif
                end
            end
            ST_ISSUE: begin
                if (!p0_ready) begin
                    p0_wr_d = 1'b0;
                    p0_rd_d = 1'b0;
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (p0_ready) begin
                    ack_d[owner_q]  = 1'b1;
                    pend_d[owner_q] = 1'b0;
                    if (!op_wr_q[owner_q]) begin
                        rq_d[owner_q] = p0_q;
                    end
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            pend_q     <= 2'b00;
            op_wr_q    <= 2'b00;
            owner_q    <= 1'b0;
            ack_q      <= 2'b00;
            buf_addr_q <= '{default: '0};
            buf_data_q <= '{default: '0};
            buf_be_q   <= '{default: '0};
            rq_q       <= '{default: '0};
            p0_addr_q  <= '0;
            p0_data_q  <= '0;
            p0_be_q    <= '0;
            p0_wr_q    <= 1'b0;
            p0_rd_q    <= 1'b0;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
            rr_ptr_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            op_wr_q    <= op_wr_d;
            owner_q    <= owner_d;
            ack_q      <= ack_d;
            buf_addr_q <= buf_addr_d;
            buf_data_q <= buf_data_d;
            buf_be_q   <= buf_be_d;
            rq_q       <= rq_d;
            p0_addr_q  <= p0_addr_d;
            p0_data_q  <= p0_data_d;
            p0_be_q    <= p0_be_d;
            p0_wr_q    <= p0_wr_d;
            p0_rd_q    <= p0_rd_d;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
            rr_ptr_q   <= rr_ptr_d;
`endif
        end
    end

    assign r0_busy    = pend_q[0];
    assign r1_busy    = pend_q[1];
    assign r0_ack     = ack_q[0];
    assign r1_ack     = ack_q[1];
    assign r0_q       = rq_q[0];
    assign r1_q       = rq_q[1];
    assign p0_addr    = p0_addr_q;
    assign p0_data    = p0_data_q;
    assign p0_byte_en = p0_be_q;
    assign p0_wr_req  = p0_wr_q;
    assign p0_rd_req  = p0_rd_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb_sdram_port_arbiter: random + directed bench with a transaction model
// of the arbiter and a behavioural sdram port-0 responder with memory.
module tb_sdram_port_arbiter;

    localparam int AW = 21;
    localparam int DW = 32;
    localparam int BW = 4;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          init_complete = 1'b0;
    logic [AW-1:0] r0_addr = '0, r1_addr = '0;
    logic [DW-1:0] r0_data = '0, r1_data = '0;
    logic [BW-1:0] r0_byte_en = '0, r1_byte_en = '0;
    logic          r0_wr_req = 0, r0_rd_req = 0;
    logic          r1_wr_req = 0, r1_rd_req = 0;
    logic          r0_busy, r1_busy, r0_ack, r1_ack;
    logic [DW-1:0] r0_q, r1_q;
    logic [AW-1:0] p0_addr;
    logic [DW-1:0] p0_data;
    logic [BW-1:0] p0_byte_en;
    logic          p0_wr_req, p0_rd_req;
    logic [DW-1:0] p0_q = '0;
    logic          p0_ready = 1'b1;

    always #5 clk = ~clk;

    sdram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW)) dut (
        .clk(clk), .reset_n(reset_n), .init_complete(init_complete),
        .r0_addr(r0_addr), .r0_data(r0_data), .r0_byte_en(r0_byte_en),
        .r0_wr_req(r0_wr_req), .r0_rd_req(r0_rd_req),
        .r0_busy(r0_busy), .r0_ack(r0_ack), .r0_q(r0_q),
        .r1_addr(r1_addr), .r1_data(r1_data), .r1_byte_en(r1_byte_en),
        .r1_wr_req(r1_wr_req), .r1_rd_req(r1_rd_req),
        .r1_busy(r1_busy), .r1_ack(r1_ack), .r1_q(r1_q),
        .p0_addr(p0_addr), .p0_data(p0_data), .p0_byte_en(p0_byte_en),
        .p0_wr_req(p0_wr_req), .p0_rd_req(p0_rd_req),
        .p0_q(p0_q), .p0_ready(p0_ready)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // transaction model: buffered request per requester, one transfer in flight
    logic [AW-1:0] m_addr [2];
    logic [DW-1:0] m_data [2];
    logic [BW-1:0] m_be   [2];
    bit            m_wr   [2];
    logic [DW-1:0] m_rq   [2];
    bit [1:0]      m_busy;
    int            ph;        // 0 none, 1 strobe up, 2 controller working
    int            owner;
    bit            m_ptr;
    int            n_gnt;
    int            first_owner;
    logic [AW-1:0] g_addr;
    logic [DW-1:0] g_data;
    logic [BW-1:0] g_be;
    logic          g_wr;

    // sdram port-0 responder
    logic [DW-1:0] mem [logic [AW-1:0]];
    int            c_st, c_cnt;
    bit            c_wr;
    logic [AW-1:0] c_addr;
    logic [DW-1:0] c_data;
    logic [BW-1:0] c_be;

    function automatic logic [DW-1:0] mem_rd(logic [AW-1:0] a);
        return mem.exists(a) ? mem[a] : {11'h5a5, a};
    endfunction

    task automatic model_reset();
        m_busy = '0;
        m_rq[0] = '0;
        m_rq[1] = '0;
        ph = 0;
        owner = 0;
        m_ptr = 1'b0;
        c_st = 0;
        p0_ready = 1'b1;
    endtask

    task automatic ctrl_step();
        logic [DW-1:0] v;
        p0_q = $urandom;
        if (c_st == 0 && (p0_wr_req || p0_rd_req)) begin
            c_wr = p0_wr_req;
            c_addr = p0_addr;
            c_data = p0_data;
            c_be = p0_byte_en;
            c_cnt = $urandom_range(0, 2);
            c_st = 1;
        end
        if (c_st == 1) begin
            if (c_cnt == 0) begin
                p0_ready = 1'b0;
                c_cnt = $urandom_range(0, 3);
                c_st = 2;
            end else c_cnt--;
        end else if (c_st == 2) begin
            if (c_cnt == 0) begin
                if (c_wr) begin
                    v = mem_rd(c_addr);
                    for (int b = 0; b < BW; b++)
                        if (c_be[b]) v[8*b +: 8] = c_data[8*b +: 8];
                    mem[c_addr] = v;
                end else begin
                    p0_q = mem_rd(c_addr);
                end
                p0_ready = 1'b1;
                c_st = 0;
            end else c_cnt--;
        end
    endtask

    task automatic cap(int n, bit wr, logic [AW-1:0] a, logic [DW-1:0] d, logic [BW-1:0] be);
        m_busy[n] = 1'b1;
        m_wr[n] = wr;
        m_addr[n] = a;
        m_data[n] = d;
        m_be[n] = be;
    endtask

    // one clock: predict the edge, take it, check outputs 1 ns later
    task automatic cycle();
        bit [1:0] ack_e;
        bit gnt;
        int w;
        ack_e = '0;
        gnt = 1'b0;
        w = 0;
        if (ph == 0 && init_complete && reset_n && m_busy != 0) begin
            gnt = 1'b1;
            if (m_busy == 2'b11) w = RR ? int'(m_ptr) : 0;
            else w = m_busy[1] ? 1 : 0;
        end
        if ((r0_wr_req || r0_rd_req) && !m_busy[0])
            cap(0, r0_wr_req, r0_addr, r0_data, r0_byte_en);
        if ((r1_wr_req || r1_rd_req) && !m_busy[1])
            cap(1, r1_wr_req, r1_addr, r1_data, r1_byte_en);
        if (ph == 1 && !p0_ready) ph = 2;
        else if (ph == 2 && p0_ready) begin
            ack_e[owner] = 1'b1;
            m_busy[owner] = 1'b0;
            if (!m_wr[owner]) m_rq[owner] = p0_q;
            ph = 0;
        end

        @(posedge clk);
        #1;

        if (gnt) begin
            ph = 1;
            owner = w;
            m_ptr = (w == 0);
            n_gnt++;
            if (first_owner < 0) first_owner = w;
            g_addr = p0_addr;
            g_data = p0_data;
            g_be = p0_byte_en;
            g_wr = p0_wr_req;
        end
        if (ph == 1) begin
            check("p0_wr_req", p0_wr_req, m_wr[owner]);
            check("p0_rd_req", p0_rd_req, !m_wr[owner]);
        end else begin
            check("p0_strobes", {p0_wr_req, p0_rd_req}, 0);
        end
        if (ph != 0) begin
            check("p0_addr", p0_addr, m_addr[owner]);
            check("p0_data", p0_data, m_data[owner]);
            check("p0_byte_en", p0_byte_en, m_be[owner]);
        end
        check("ack", {r1_ack, r0_ack}, ack_e);
        check("busy", {r1_busy, r0_busy}, m_busy);
        check("r0_q", r0_q, m_rq[0]);
        check("r1_q", r1_q, m_rq[1]);
        ctrl_step();
    endtask

    task automatic clear_reqs();
        r0_wr_req = 0; r0_rd_req = 0;
        r1_wr_req = 0; r1_rd_req = 0;
    endtask

    task automatic pulse(int n, bit wr, bit rd, logic [AW-1:0] a, logic [DW-1:0] d, logic [BW-1:0] be);
        if (n == 0) begin
            r0_wr_req = wr; r0_rd_req = rd; r0_addr = a; r0_data = d; r0_byte_en = be;
        end else begin
            r1_wr_req = wr; r1_rd_req = rd; r1_addr = a; r1_data = d; r1_byte_en = be;
        end
    endtask

    task automatic rand_req(int n);
        int k;
        if ($urandom_range(0, 3) == 0) begin
            k = $urandom_range(0, 9);
            pulse(n, k < 4 || k == 9, k >= 4, 21'h100 + 21'($urandom_range(0, 15)),
                  $urandom, 4'($urandom));
        end
    endtask

    task automatic drain();
        int k = 0;
        while ((m_busy != 0 || ph != 0) && k < 200) begin
            cycle();
            k++;
        end
        check("drain_timeout", (m_busy != 0 || ph != 0), 0);
    endtask

    task automatic reset_chk(string tag);
        check({tag, "_p0"}, {p0_wr_req, p0_rd_req, p0_addr, p0_data, p0_byte_en}, 0);
        check({tag, "_busy_ack"}, {r1_busy, r0_busy, r1_ack, r0_ack}, 0);
        check({tag, "_q"}, {r1_q, r0_q}, 0);
    endtask

    initial begin
        model_reset();
        n_gnt = 0;
        first_owner = -1;
        @(posedge clk);
        #1;
        reset_chk("reset");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        cycle();

        // early request while init low, plus an ignored pulse while busy
        pulse(0, 1, 0, 21'h2020, 32'h1234, 4'hF);
        cycle();
        clear_reqs();
        pulse(0, 1, 0, 21'h2021, 32'hBEEF, 4'h3);
        cycle();
        clear_reqs();
        repeat (4) cycle();
        check("early_no_grant", n_gnt, 0);
        init_complete = 1'b1;
        drain();
        check("early_grant_once", n_gnt, 1);
        check("wr_addr", g_addr, 21'h2020);
        check("wr_data", g_data, 32'h1234);
        check("wr_be", g_be, 4'hF);
        check("wr_op", g_wr, 1);

        // r1 reads back the write
        pulse(1, 0, 1, 21'h2020, 32'h0, 4'h0);
        cycle();
        clear_reqs();
        drain();
        check("rd_r1_q", r1_q, 32'h1234);
        check("rd_r0_q_held", r0_q, 0);

        // simultaneous pulses: r0 goes first in either mode from here
        for (int i = 0; i < 3; i++) begin
            first_owner = -1;
            pulse(0, 1, 0, 21'h3000 + 21'(i), $urandom, 4'hF);
            pulse(1, 0, 1, 21'h3000 + 21'(i), 32'h0, 4'h0);
            cycle();
            clear_reqs();
            drain();
            check("contention_first", first_owner, 0);
        end

        // random traffic with short init-low windows
        for (int i = 0; i < 1500; i++) begin
            init_complete = !((i % 300) < 5 && i > 0);
            rand_req(0);
            rand_req(1);
            cycle();
            clear_reqs();
        end
        init_complete = 1'b1;
        drain();

        // reset while the controller is working on a write
        pulse(0, 1, 0, 21'h2040, 32'hCAFE, 4'hF);
        cycle();
        clear_reqs();
        for (int k = 0; k < 50 && ph != 2; k++) cycle();
        check("rst_reach_wait", ph, 2);
        #2;
        reset_n = 1'b0;
        #1;
        reset_chk("rst_mid");
        model_reset();
        cycle();
        cycle();
        reset_n = 1'b1;
        pulse(1, 0, 1, 21'h2020, 32'h0, 4'h0);
        cycle();
        clear_reqs();
        drain();
        check("post_rst_rd", r1_q, 32'h1234);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
